// File: rtl/mode_key_ctrl.sv
// Front-panel key stage: synchronises and debounces the mode and LED buttons and
// steps mode_select / led_select. Optional long-press reset via MODE_KEY_LONGPRESS_EN.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module mode_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MODE_NUM        = 4,
    parameter int LED_NUM         = 8
`ifdef MODE_KEY_LONGPRESS_EN
    , parameter int LONG_CYCLES   = 50000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_led_n,
    output logic [3:0] mode_select,
    output logic [3:0] led_select,
    output logic       mode_changed
);
    localparam logic [3:0] MODE_MAX = 4'(MODE_NUM - 1);
    localparam logic [3:0] LED_MAX  = 4'(LED_NUM - 1);

`ifdef MODE_KEY_LONGPRESS_EN
    typedef enum logic [1:0] {IDLE, PRESSED, LONG} key_state_t;
`else
    typedef enum logic {IDLE, PRESSED} key_state_t;
`endif

    logic       mode_level;
    logic       led_level;
    key_state_t mode_state, mode_state_nxt;
    key_state_t led_state, led_state_nxt;
    logic       mode_step;
    logic       mode_clear;
    logic       led_step;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_mode_n),
        .level (mode_level)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_led (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_led_n),
        .level (led_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_state <= IDLE;
            led_state  <= IDLE;
        end else begin
            mode_state <= mode_state_nxt;
            led_state  <= led_state_nxt;
        end
    end

`ifdef MODE_KEY_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Hold time is measured from entry into PRESSED; it restarts on every new press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (mode_state != PRESSED) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_comb begin
        mode_state_nxt = mode_state;
        case (mode_state)
            IDLE:    if (!mode_level) mode_state_nxt = PRESSED;
            PRESSED: if (mode_level) mode_state_nxt = IDLE;
                     else if (hold_cnt == HOLD_MAX) mode_state_nxt = LONG;
            LONG:    if (mode_level) mode_state_nxt = IDLE;
            default: mode_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mode_step  = (mode_state == PRESSED) && mode_level;
        mode_clear = (mode_state == PRESSED) && !mode_level && (hold_cnt == HOLD_MAX);
    end
`else
    // NOTE: every always_comb output gets a default assignment first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        mode_state_nxt = mode_state;
        case (mode_state)
            IDLE:    if (!mode_level) mode_state_nxt = PRESSED;
            PRESSED: if (mode_level) mode_state_nxt = IDLE;
            default: mode_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mode_step  = (mode_state == IDLE) && !mode_level;
        mode_clear = 1'b0;
    end
`endif

    always_comb begin
        led_state_nxt = led_state;
        case (led_state)
            IDLE:    if (!led_level) led_state_nxt = PRESSED;
            PRESSED: if (led_level) led_state_nxt = IDLE;
            default: led_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        led_step = (led_state == IDLE) && !led_level;
    end

    // A long-press clear overrides any LED step landing on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_select  <= '0;
            led_select   <= '0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= mode_step || mode_clear;
            if (mode_clear) begin
                mode_select <= '0;
                led_select  <= '0;
            end else begin
                if (mode_step)
                    mode_select <= (mode_select == MODE_MAX) ? 4'd0 : mode_select + 4'd1;
                if (led_step)
                    led_select <= (led_select == LED_MAX) ? 4'd0 : led_select + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mode_key_ctrl.sv
// Scoreboard bench for mode_key_ctrl with DEBOUNCE_CYCLES=16 (LONG_CYCLES=64 when
// MODE_KEY_LONGPRESS_EN is defined).

module tb_mode_key_ctrl;
    localparam int LAT = 19;

    logic       clk;
    logic       rst;
    logic       key_mode_n;
    logic       key_led_n;
    logic [3:0] mode_select;
    logic [3:0] led_select;
    logic       mode_changed;

    typedef struct {
        int mode;
        int led;
        int chg;
        int cyc;
    } evt_t;

    evt_t exp_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   t0, t1;
    logic [3:0] last_mode = 4'd0;
    logic [3:0] last_led  = 4'd0;

    mode_key_ctrl #(
        .DEBOUNCE_CYCLES (16),
        .MODE_NUM        (4),
        .LED_NUM         (8)
`ifdef MODE_KEY_LONGPRESS_EN
        , .LONG_CYCLES   (64)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_mode_n   (key_mode_n),
        .key_led_n    (key_led_n),
        .mode_select  (mode_select),
        .led_select   (led_select),
        .mode_changed (mode_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int m, input int l, input int c, input int at);
        evt_t e;
        e.mode = m;
        e.led  = l;
        e.chg  = c;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key_down(input bit m, input bit l);
        if (m) key_mode_n = 1'b0;
        if (l) key_led_n  = 1'b0;
        t0 = cyc;
    endtask

    task automatic key_up(input bit m, input bit l);
        if (m) key_mode_n = 1'b1;
        if (l) key_led_n  = 1'b1;
        t1 = cyc;
    endtask

    // One press of the given key(s); the expected output lands LAT edges after
    // the first low sample, or after the first high sample when on_rel is set.
    task automatic tap(input bit m, input bit l, input int hold, input bit on_rel,
                       input int em, input int el, input int ec);
        key_down(m, l);
        if (!on_rel) push(em, el, ec, t0 + LAT);
        wait_cyc(hold);
        key_up(m, l);
        if (on_rel) push(em, el, ec, t1 + LAT);
        wait_cyc(30);
    endtask

    // Monitor: any value change or mode_changed pulse is one DUT output event.
    always @(negedge clk) begin
        evt_t e;
        if (rst) begin
            last_mode = 4'd0;
            last_led  = 4'd0;
        end else begin
            if (mode_changed || mode_select != last_mode || led_select != last_led) begin
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL unexpected_event: got mode=%0d led=%0d chg=%0b at cyc %0d, required no event",
                             mode_select, led_select, mode_changed, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_mode", int'(mode_select), e.mode);
                    check("evt_led", int'(led_select), e.led);
                    check("evt_chg", int'(mode_changed), e.chg);
                    check("evt_cyc", cyc, e.cyc);
                end
            end
            last_mode = mode_select;
            last_led  = led_select;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cyc %0d, required test end", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        key_mode_n = 1'b1;
        key_led_n  = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        check("rst_mode", int'(mode_select), 0);
        check("rst_led", int'(led_select), 0);
        check("rst_chg", int'(mode_changed), 0);

`ifdef MODE_KEY_LONGPRESS_EN
        for (int i = 1; i <= 5; i++) tap(1'b0, 1'b1, 40, 1'b0, 0, i, 0);
        tap(1'b1, 1'b0, 40, 1'b1, 1, 5, 1);
        tap(1'b1, 1'b0, 40, 1'b1, 2, 5, 1);
        // Long hold: PRESSED entered at t0+19, clear 64 edges later; release is silent.
        key_down(1'b1, 1'b0);
        push(0, 0, 1, t0 + LAT + 64);
        wait_cyc(100);
        key_up(1'b1, 1'b0);
        wait_cyc(30);
        tap(1'b1, 1'b0, 30, 1'b1, 1, 0, 1);
`else
        tap(1'b1, 1'b0, 40, 1'b0, 1, 0, 1);
        tap(1'b1, 1'b0, 40, 1'b0, 2, 0, 1);
        tap(1'b1, 1'b0, 40, 1'b0, 3, 0, 1);
        tap(1'b1, 1'b0, 40, 1'b0, 0, 0, 1);

        // Bounce: 10 low, 3 high, 40 low -> one step timed from the final low.
        key_down(1'b1, 1'b0);
        wait_cyc(10);
        key_up(1'b1, 1'b0);
        wait_cyc(3);
        key_down(1'b1, 1'b0);
        push(1, 0, 1, t0 + LAT);
        wait_cyc(40);
        key_up(1'b1, 1'b0);
        wait_cyc(30);

        // A 15-cycle glitch is rejected; 16 cycles is the shortest accepted press.
        key_down(1'b1, 1'b0);
        wait_cyc(15);
        key_up(1'b1, 1'b0);
        wait_cyc(30);
        tap(1'b0, 1'b1, 16, 1'b0, 1, 1, 0);

        for (int i = 2; i <= 7; i++) tap(1'b0, 1'b1, 40, 1'b0, 1, i, 0);
        tap(1'b1, 1'b0, 40, 1'b0, 2, 7, 1);
        tap(1'b1, 1'b1, 40, 1'b0, 3, 0, 1);

        // Reset mid-debounce clears asynchronously; held key re-debounces as a fresh press.
        key_down(1'b1, 1'b0);
        wait_cyc(8);
        #3 rst = 1'b1;
        #1;
        check("async_rst_mode", int'(mode_select), 0);
        check("async_rst_led", int'(led_select), 0);
        check("async_rst_chg", int'(mode_changed), 0);
        wait_cyc(2);
        rst = 1'b0;
        t0 = cyc;
        push(1, 0, 1, t0 + LAT);
        wait_cyc(40);
        key_up(1'b1, 1'b0);
        wait_cyc(30);
`endif

        wait_cyc(20);
        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
